// File: rtl/lut_func_sweeper_pkg.sv
// lut_func_pkg: shared state encoding and truth-table sizing for the LUT function sweeper
package lut_func_pkg;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_e;

    // Total truth-table bits: one row of 2**n_in minterms per function
    function automatic int tt_bits(input int n_in, input int n_out);
        return n_out * (1 << n_in);
    endfunction

endpackage

// File: rtl/lut_func_sweeper_if.sv
// lut_func_if: config, eval and sweep signal bundle between a driver and the sweeper
interface lut_func_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2
);

    logic                      cfg_valid;
    logic                      cfg_bit;
    logic                      cfg_ready;
    logic                      table_ok;
    logic                      eval_valid;
    logic [N_IN-1:0]           eval_in;
    logic                      f_valid;
    logic [N_OUT-1:0]          f_out;
    logic                      sweep_start;
    logic                      sweep_busy;
    logic                      sweep_valid;
    logic [N_IN-1:0]           sweep_idx;
    logic [N_OUT-1:0]          sweep_f;
    logic                      sweep_done;
    logic [N_OUT*(N_IN+1)-1:0] onset_cnt;

    modport master (
        output cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start,
        input  cfg_ready, table_ok, f_valid, f_out, sweep_busy, sweep_valid,
               sweep_idx, sweep_f, sweep_done, onset_cnt
    );

    modport slave (
        input  cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start,
        output cfg_ready, table_ok, f_valid, f_out, sweep_busy, sweep_valid,
               sweep_idx, sweep_f, sweep_done, onset_cnt
    );

endinterface

// File: rtl/lut_func_sweeper_table.sv
// lut_func_table: serial truth-table loader with shadow/committed copies and two minterm read ports
module lut_func_table
    import lut_func_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_bit,
    input  logic [N_IN-1:0]  rd_a_idx,
    input  logic [N_IN-1:0]  rd_b_idx,
    output logic [N_OUT-1:0] rd_a_f,
    output logic [N_OUT-1:0] rd_b_f,
    output logic             table_ok,
    output logic             cnt_zero
);

    localparam int TT_BITS = tt_bits(N_IN, N_OUT);
    localparam int CW      = $clog2(TT_BITS);
    localparam int ROW     = 1 << N_IN;

    logic [TT_BITS-1:0] shadow_q, shadow_d;
    logic [TT_BITS-1:0] table_q, table_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               table_ok_q, table_ok_d;
    logic               last;

    // Bits enter at the top so stream position p lands on table bit p; the final bit commits the shadow
    always_comb begin
        last       = cfg_we && (cnt_q == CW'(TT_BITS - 1));
        shadow_d   = cfg_we ? {cfg_bit, shadow_q[TT_BITS-1:1]} : shadow_q;
        cnt_d      = last ? '0 : cnt_q + CW'(cfg_we);
        table_d    = last ? shadow_d : table_q;
        table_ok_d = table_ok_q | last;
    end

    // Loader state; reset discards both the committed table and any partial load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            table_q    <= '0;
            cnt_q      <= '0;
            table_ok_q <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            table_q    <= table_d;
            cnt_q      <= cnt_d;
            table_ok_q <= table_ok_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_rd
        logic [ROW-1:0] row;
        assign row       = table_q[k*ROW +: ROW];
        assign rd_a_f[k] = row[rd_a_idx];
        assign rd_b_f[k] = row[rd_b_idx];
    end

    assign table_ok = table_ok_q;
    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/lut_func_sweeper.sv
// lut_func_sweeper: programmable truth-table functions with registered eval and exhaustive ON-set sweep
module lut_func_sweeper
    import lut_func_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2
) (
    input logic       clk,
    input logic       rst_n,
    lut_func_if.slave bus
);

    localparam int              CNT_W   = N_IN + 1;
    localparam logic [N_IN-1:0] IDX_MAX = '1;

    state_e                    state_q, state_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      f_valid_q, f_valid_d;
    logic [N_OUT-1:0]          f_out_q, f_out_d;
    logic                      busy_q, busy_d;
    logic [N_IN-1:0]           idx_q, idx_d;
    logic                      done_q, done_d;
    logic [N_OUT*CNT_W-1:0]    onset_q, onset_d;
    logic [N_OUT-1:0]          rd_a, rd_b;
    logic                      table_ok, cnt_zero;
    logic                      start, in_sweep;

    lut_func_table #(
        .N_IN (N_IN),
        .N_OUT(N_OUT)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_we  (bus.cfg_valid && cfg_ready_q),
        .cfg_bit (bus.cfg_bit),
        .rd_a_idx(bus.eval_in),
        .rd_b_idx(idx_q),
        .rd_a_f  (rd_a),
        .rd_b_f  (rd_b),
        .table_ok(table_ok),
        .cnt_zero(cnt_zero)
    );

    // Next-state for eval register, sweep FSM and ON-set counters; a sweep starts only on a stable committed table
    always_comb begin
        in_sweep    = (state_q == SWEEP);
        start       = (state_q == IDLE) && bus.sweep_start && table_ok && cnt_zero;
        state_d     = start ? SWEEP : (in_sweep && idx_q == IDX_MAX) ? IDLE : state_q;
        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d == SWEEP);
        idx_d       = start ? '0 : (in_sweep && idx_q != IDX_MAX) ? idx_q + 1'b1 : idx_q;
        done_d      = in_sweep && (idx_q == IDX_MAX - 1'b1);
        f_valid_d   = bus.eval_valid;
        f_out_d     = bus.eval_valid ? rd_a : f_out_q;
        onset_d     = start ? '0 : onset_q;
        if (in_sweep)
            for (int k = 0; k < N_OUT; k++)
                onset_d[k*CNT_W +: CNT_W] = onset_q[k*CNT_W +: CNT_W] + CNT_W'(rd_b[k]);
    end

    // All control outputs are registered; reset lands in IDLE ready to accept configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            f_valid_q   <= 1'b0;
            f_out_q     <= '0;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            onset_q     <= '0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            f_valid_q   <= f_valid_d;
            f_out_q     <= f_out_d;
            busy_q      <= busy_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            onset_q     <= onset_d;
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.table_ok    = table_ok;
    assign bus.f_valid     = f_valid_q;
    assign bus.f_out       = f_out_q;
    assign bus.sweep_busy  = busy_q;
    assign bus.sweep_valid = busy_q;
    assign bus.sweep_idx   = idx_q;
    assign bus.sweep_f     = busy_q ? rd_b : '0;
    assign bus.sweep_done  = done_q;
    assign bus.onset_cnt   = onset_q;

endmodule
